// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU and its 8-bit command sequencer.
package alu4_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } seq_state_t;

    // Add and sub are the only ops whose low-nibble carry/borrow ripples upward.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu8_seq_if.sv
// Command/response handshake bundle between control logic and alu8_seq.
interface alu8_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu4bits.sv
// Combinational 4-bit ALU; sub reports borrow (a < b) on carry, illegal ops give 0.
module alu4bits
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero
);

    // Select the operation; the 5th bit of add/sub is carry-out / borrow.
    always_comb begin
        result = 4'd0;
        carry  = 1'b0;
        case (sel)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: ;
        endcase
    end

    assign zero = (result == 4'd0);

endmodule

// File: rtl/alu8_seq.sv
// 8-bit operation sequencer driving an external 4-bit ALU in nibble passes.
// A FIX pass adds/subtracts 1 to the high nibble when the low pass carried.
module alu8_seq
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu8_seq_if.slave  bus,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero
);

    seq_state_t state, state_nx;

    logic [2:0] op_q;
    logic [3:0] a_hi, b_hi;
    logic [3:0] res_lo, res_hi;
    logic       c_lo, c_hi, c_fix;
    logic       z_lo, z_hi;
    logic       rsp_valid_q;
    logic       fix_need;

    assign fix_need = is_arith(op_q) && c_lo;

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = {res_hi, res_lo};
    assign bus.rsp_carry  = is_arith(op_q) & (c_hi | c_fix);
    assign bus.rsp_zero   = z_lo & z_hi;
    assign bus.rsp_err    = (op_q > OP_XOR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode: LO -> HI always, FIX only when a low carry must ripple.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.cmd_valid) state_nx = S_LO;
            S_LO:    state_nx = S_HI;
            S_HI:    state_nx = fix_need ? S_FIX : S_DONE;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  if (bus.rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: latch command, sample each ALU pass, stage next ALU operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 3'd0;
            a_hi        <= 4'd0;
            b_hi        <= 4'd0;
            res_lo      <= 4'd0;
            res_hi      <= 4'd0;
            c_lo        <= 1'b0;
            c_hi        <= 1'b0;
            c_fix       <= 1'b0;
            z_lo        <= 1'b0;
            z_hi        <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_sel     <= 3'd0;
        end else begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    a_hi    <= bus.cmd_a[7:4];
                    b_hi    <= bus.cmd_b[7:4];
                    c_fix   <= 1'b0;
                    alu_a   <= bus.cmd_a[3:0];
                    alu_b   <= bus.cmd_b[3:0];
                    alu_sel <= bus.cmd_op;
                end
                S_LO: begin
                    res_lo <= alu_result;
                    c_lo   <= alu_carry;
                    z_lo   <= alu_zero;
                    alu_a  <= a_hi;
                    alu_b  <= b_hi;
                end
                S_HI: begin
                    res_hi <= alu_result;
                    c_hi   <= alu_carry;
                    z_hi   <= alu_zero;
                    if (fix_need) begin
                        // Same op with operand 1 propagates the low carry/borrow.
                        alu_a <= alu_result;
                        alu_b <= 4'b0001;
                    end else begin
                        alu_a       <= 4'd0;
                        alu_b       <= 4'd0;
                        alu_sel     <= 3'd0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_FIX: begin
                    res_hi      <= alu_result;
                    z_hi        <= alu_zero;
                    c_fix       <= alu_carry;
                    alu_a       <= 4'd0;
                    alu_b       <= 4'd0;
                    alu_sel     <= 3'd0;
                    rsp_valid_q <= 1'b1;
                end
                S_DONE: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_seq.sv
// Directed bench for alu8_seq wired to alu4bits; expected values hand-computed.
module tb_alu8_seq;
    import alu4_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero;

    int n_chk = 0;
    int n_err = 0;

    alu8_seq_if bus ();

    alu8_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero)
    );

    alu4bits u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .sel    (alu_sel),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One command: accept, check LO operands, latency, response, optional hold, release.
    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ec, input logic ez, input logic ee,
                       input int elat, input int hold);
        int n;
        logic [3:0] a_lo;
        a_lo = a[3:0];
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        n = 1;
        chk("lo_alu_a", 32'(alu_a), 32'(a_lo));
        chk("lo_alu_sel", 32'(alu_sel), 32'(op));
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(elat));
        chk("result", 32'(bus.rsp_result), 32'(er));
        chk("carry", 32'(bus.rsp_carry), 32'(ec));
        chk("zero", 32'(bus.rsp_zero), 32'(ez));
        chk("err", 32'(bus.rsp_err), 32'(ee));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_result", 32'(bus.rsp_result), 32'(er));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("hold_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_flags", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_err}), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   op      a      b      result carry zero err lat hold
        run(OP_ADD, 8'h3A, 8'h47, 8'h81, 1'b0, 1'b0, 1'b0, 4, 5);
        run(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 4, 0);
        run(OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 3, 0);
        run(OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 4, 0);
        run(OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 4, 0);
        run(OP_XOR, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 3, 0);
        run(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 3, 0);
        run(3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 3, 2);

        // Reset during the HI pass of 0x3A+0x47: alu_a holds high nibble 3.
        @(negedge clk);
        bus.cmd_op    = OP_ADD;
        bus.cmd_a     = 8'h3A;
        bus.cmd_b     = 8'h47;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hi_alu_a", 32'(alu_a), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_result", 32'(bus.rsp_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);

        run(OP_OR, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
